// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared state encoding and bus widths for mem_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : requester, memory and control signals of mem_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              sig_hlt;
  logic              IF_req;
  logic [ADDR_W-1:0] IF_addr_pgm;
  logic              IF_gnt;
  logic              IF_valid;
  logic [DATA_W-1:0] IF_data;
  logic              DM_req;
  logic              DM_we;
  logic [ADDR_W-1:0] DM_addr;
  logic [DATA_W-1:0] DM_wdata;
  logic              DM_gnt;
  logic              DM_valid;
  logic [DATA_W-1:0] DM_rdata;
  logic              MEM_en;
  logic              MEM_we;
  logic [ADDR_W-1:0] MEM_addr;
  logic [DATA_W-1:0] MEM_wdata;
  logic [DATA_W-1:0] MEM_rdata;
  logic              sig_stall_IF;
  logic              sig_idle;

  // Requesters, control ROM and memory side
  modport master (
    output sig_hlt, IF_req, IF_addr_pgm, DM_req, DM_we, DM_addr, DM_wdata, MEM_rdata,
    input  IF_gnt, IF_valid, IF_data, DM_gnt, DM_valid, DM_rdata,
           MEM_en, MEM_we, MEM_addr, MEM_wdata, sig_stall_IF, sig_idle
  );

  // Arbiter side
  modport slave (
    input  sig_hlt, IF_req, IF_addr_pgm, DM_req, DM_we, DM_addr, DM_wdata, MEM_rdata,
    output IF_gnt, IF_valid, IF_data, DM_gnt, DM_valid, DM_rdata,
           MEM_en, MEM_we, MEM_addr, MEM_wdata, sig_stall_IF, sig_idle
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_arb_prio.sv
// ============================================================================
// arb_prio : DM-first priority with a starvation counter protecting fetches
// Revision 1.0
// ============================================================================
`default_nettype none

module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       IF_req,
  input  wire logic       DM_req,
  input  wire arb_state_e state,
  output logic            IF_gnt,
  output logic            DM_gnt
);

  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             w_starved;

  assign w_starved = (starve_cnt == LIMIT);

  always_comb begin
    IF_gnt = 1'b0;
    DM_gnt = 1'b0;
    if (state == RUN) begin
      if (DM_req && !(IF_req && w_starved)) begin
        DM_gnt = 1'b1;
      end else if (IF_req) begin
        IF_gnt = 1'b1;
      end
    end
  end

  // Counts DM wins that left a fetch waiting; an IF grant resets the streak.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (IF_gnt) begin
      starve_cnt <= '0;
    end else if (DM_gnt && IF_req && !w_starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : single-port memory arbiter between fetch and data requesters
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  wire logic     sig_clk,
  input  wire logic     sig_rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       w_if_req;
  logic       w_dm_req;
  logic       w_if_gnt;
  logic       w_dm_gnt;
  logic       r_if_valid;
  logic       r_dm_valid;
  logic       r_dm_rd;

  // Halt and reset both suppress grants in the cycle they are seen.
  assign w_if_req = bus.IF_req & ~bus.sig_hlt & ~sig_rst;
  assign w_dm_req = bus.DM_req & ~bus.sig_hlt & ~sig_rst;

  arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk    (sig_clk),
    .rst    (sig_rst),
    .IF_req (w_if_req),
    .DM_req (w_dm_req),
    .state  (r_state),
    .IF_gnt (w_if_gnt),
    .DM_gnt (w_dm_gnt)
  );

  always_ff @(posedge sig_clk) begin
    if (sig_rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    bus.sig_idle = 1'b0;
    case (r_state)
      RUN:     if (bus.sig_hlt) w_state_next = DRAIN;
      DRAIN:   w_state_next = HALTED;
      HALTED:  begin
        w_state_next = HALTED;
        bus.sig_idle = 1'b1;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge sig_clk) begin
    if (sig_rst) begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_dm_rd    <= 1'b0;
    end else begin
      r_if_valid <= w_if_gnt;
      r_dm_valid <= w_dm_gnt;
      r_dm_rd    <= w_dm_gnt & ~bus.DM_we;
    end
  end

  assign bus.IF_gnt       = w_if_gnt;
  assign bus.DM_gnt       = w_dm_gnt;
  assign bus.IF_valid     = r_if_valid;
  assign bus.DM_valid     = r_dm_valid;
  assign bus.IF_data      = r_if_valid ? bus.MEM_rdata : '0;
  assign bus.DM_rdata     = r_dm_rd ? bus.MEM_rdata : '0;
  assign bus.sig_stall_IF = bus.IF_req & ~w_if_gnt;

  always_comb begin
    bus.MEM_en    = 1'b0;
    bus.MEM_we    = 1'b0;
    bus.MEM_addr  = '0;
    bus.MEM_wdata = '0;
    if (w_dm_gnt) begin
      bus.MEM_en    = 1'b1;
      bus.MEM_we    = bus.DM_we;
      bus.MEM_addr  = bus.DM_addr;
      bus.MEM_wdata = bus.DM_we ? bus.DM_wdata : '0;
    end else if (w_if_gnt) begin
      bus.MEM_en    = 1'b1;
      bus.MEM_addr  = bus.IF_addr_pgm;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed stimulus with a per-cycle reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int LIMIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .sig_clk (clk),
    .sig_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Environment memory: registered read, one cycle latency
  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  logic [7:0] mem_q = 8'h00;
  assign bus.MEM_rdata = mem_q;

  always @(posedge clk) begin
    if (bus.MEM_en) begin
      if (bus.MEM_we) mem[bus.MEM_addr] <= bus.MEM_wdata;
      else            mem_q <= mem[bus.MEM_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: 0=RUN 1=DRAIN 2=HALTED, starvation streak, pending responses
  int         m_state = 0;
  int         m_cnt   = 0;
  bit         p_ifv = 0, p_dmv = 0;
  logic [7:0] p_ifd = 0, p_dmd = 0;

  always @(negedge clk) begin
    bit         eg_if, eg_dm;
    logic [7:0] e_addr, e_wdata;
    eg_if = 0;
    eg_dm = 0;
    if (!rst && m_state == 0 && !bus.sig_hlt) begin
      if (bus.DM_req && !(bus.IF_req && m_cnt == LIMIT)) eg_dm = 1;
      else if (bus.IF_req) eg_if = 1;
    end
    e_addr  = eg_dm ? bus.DM_addr : (eg_if ? bus.IF_addr_pgm : 8'h00);
    e_wdata = (eg_dm && bus.DM_we) ? bus.DM_wdata : 8'h00;
    chk("IF_gnt", bus.IF_gnt, eg_if);
    chk("DM_gnt", bus.DM_gnt, eg_dm);
    chk("MEM_en", bus.MEM_en, eg_if | eg_dm);
    chk("MEM_we", bus.MEM_we, eg_dm && bus.DM_we);
    chk("MEM_addr", bus.MEM_addr, e_addr);
    chk("MEM_wdata", bus.MEM_wdata, e_wdata);
    chk("stall_IF", bus.sig_stall_IF, bus.IF_req && !eg_if);
    chk("idle", bus.sig_idle, m_state == 2);
    chk("IF_valid", bus.IF_valid, p_ifv);
    chk("IF_data", bus.IF_data, p_ifv ? p_ifd : 8'h00);
    chk("DM_valid", bus.DM_valid, p_dmv);
    chk("DM_rdata", bus.DM_rdata, p_dmv ? p_dmd : 8'h00);
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      p_ifv   = 0;
      p_dmv   = 0;
    end else begin
      p_ifv = eg_if;
      p_dmv = eg_dm;
      if (eg_if) begin
        p_ifd = shadow[bus.IF_addr_pgm];
        m_cnt = 0;
      end
      if (eg_dm) begin
        if (bus.DM_we) begin
          shadow[bus.DM_addr] = bus.DM_wdata;
          p_dmd = 8'h00;
        end else begin
          p_dmd = shadow[bus.DM_addr];
        end
        if (bus.IF_req && m_cnt < LIMIT) m_cnt++;
      end
      if (m_state == 0 && bus.sig_hlt) m_state = 1;
      else if (m_state == 1)           m_state = 2;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sig_hlt = 0; bus.IF_req = 0; bus.IF_addr_pgm = 0;
    bus.DM_req = 0; bus.DM_we = 0; bus.DM_addr = 0; bus.DM_wdata = 0;
  endtask

  typedef struct packed {
    logic       ifr;
    logic [7:0] ifa;
    logic       dmr;
    logic       we;
    logic [7:0] dma;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs [6];
  bit   exp_dm_order [6];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h3C;
      shadow[i] = 8'(i) ^ 8'h3C;
    end
    mem[8'h12]    = 8'hA5;
    shadow[8'h12] = 8'hA5;
    idle_inputs();
    exp_dm_order = '{1, 1, 0, 1, 1, 0};
    vecs[0] = '{1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h77};
    vecs[2] = '{1'b1, 8'h21, 1'b1, 1'b0, 8'h20, 8'h00};
    vecs[3] = '{1'b1, 8'h21, 1'b1, 1'b0, 8'h22, 8'h00};
    vecs[4] = '{1'b1, 8'h21, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00};

    // Reset state
    cyc(); cyc();
    chk("rst_starve_cnt", 32'(dut.u_prio.starve_cnt), 0);
    chk("rst_IF_valid", bus.IF_valid, 0);
    chk("rst_DM_rdata", bus.DM_rdata, 0);
    rst = 0;

    // Isolated fetch of 0x12
    bus.IF_req = 1; bus.IF_addr_pgm = 8'h12;
    @(negedge clk);
    chk("fetch_gnt", bus.IF_gnt, 1);
    cyc();
    bus.IF_req = 0;
    @(negedge clk);
    chk("fetch_valid", bus.IF_valid, 1);
    chk("fetch_data", bus.IF_data, 8'hA5);

    // Contention: both held for six cycles
    cyc();
    bus.IF_req = 1; bus.IF_addr_pgm = 8'h30;
    bus.DM_req = 1; bus.DM_we = 0; bus.DM_addr = 8'h40;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("contend_DM_gnt", bus.DM_gnt, exp_dm_order[k]);
      chk("contend_stall", bus.sig_stall_IF, exp_dm_order[k]);
      cyc();
    end
    idle_inputs();

    // Write 0x5A to 0x80, then read it back
    bus.DM_req = 1; bus.DM_we = 1; bus.DM_addr = 8'h80; bus.DM_wdata = 8'h5A;
    @(negedge clk);
    chk("wr_MEM_we", bus.MEM_we, 1);
    cyc();
    bus.DM_we = 0; bus.DM_wdata = 0;
    @(negedge clk);
    chk("rd_MEM_we", bus.MEM_we, 0);
    chk("wr_DM_valid", bus.DM_valid, 1);
    chk("wr_DM_rdata", bus.DM_rdata, 0);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("rd_DM_valid", bus.DM_valid, 1);
    chk("rd_DM_rdata", bus.DM_rdata, 8'h5A);
    cyc();

    // Mixed traffic checked by the model
    for (int k = 0; k < 6; k++) begin
      bus.IF_req = vecs[k].ifr; bus.IF_addr_pgm = vecs[k].ifa;
      bus.DM_req = vecs[k].dmr; bus.DM_we = vecs[k].we;
      bus.DM_addr = vecs[k].dma; bus.DM_wdata = vecs[k].wd;
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    chk("mixed_rd_FF", bus.DM_rdata, 8'hC3);
    cyc();

    // Halt after a fetch grant
    bus.IF_req = 1; bus.IF_addr_pgm = 8'h33;
    @(negedge clk);
    chk("halt_fetch_gnt", bus.IF_gnt, 1);
    cyc();
    bus.sig_hlt = 1;
    @(negedge clk);
    chk("halt_N1_gnt", bus.IF_gnt, 0);
    chk("halt_N1_valid", bus.IF_valid, 1);
    chk("halt_N1_data", bus.IF_data, 8'h0F);
    cyc();
    bus.sig_hlt = 0;
    @(negedge clk);
    chk("drain_idle", bus.sig_idle, 0);
    chk("drain_gnt", bus.IF_gnt, 0);
    cyc();
    bus.DM_req = 1; bus.DM_addr = 8'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halted_idle", bus.sig_idle, 1);
      chk("halted_gnt", bus.IF_gnt | bus.DM_gnt, 0);
      cyc();
    end

    // Reset from halt, then reset in the middle of a DM read
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    bus.DM_req = 1; bus.DM_we = 0; bus.DM_addr = 8'h44;
    @(negedge clk);
    chk("rst_rd_gnt", bus.DM_gnt, 1);
    cyc();
    bus.DM_req = 0;
    rst = 1;
    @(negedge clk);
    chk("in_rst_MEM_en", bus.MEM_en, 0);
    cyc();
    rst = 0;
    bus.IF_req = 1; bus.IF_addr_pgm = 8'h05;
    @(negedge clk);
    chk("post_rst_DM_valid", bus.DM_valid, 0);
    chk("post_rst_starve", 32'(dut.u_prio.starve_cnt), 0);
    chk("post_rst_IF_gnt", bus.IF_gnt, 1);
    cyc();
    bus.IF_req = 0;
    @(negedge clk);
    chk("post_rst_IF_data", bus.IF_data, 8'h39);
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
